// File: rtl/tb_debug_port.sv
// rtl/tb_debug_port.sv - AXI4-Lite debug/monitor slave: char FIFO, interval timers, cycle counter, scratch, finish
module tb_debug_port #(
    parameter int          DW         = 64,
    parameter int          AW         = 32,
    parameter logic [31:0] BASE       = 32'h2000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          NUM_TIMERS = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW-1:0]   AWADDR,
    input  logic            AWVALID,
    output logic            AWREADY,
    input  logic [DW-1:0]   WDATA,
    input  logic [DW/8-1:0] WSTRB,
    input  logic            WVALID,
    output logic            WREADY,
    output logic [1:0]      BRESP,
    output logic            BVALID,
    input  logic            BREADY,
    input  logic [AW-1:0]   ARADDR,
    input  logic            ARVALID,
    output logic            ARREADY,
    output logic [DW-1:0]   RDATA,
    output logic [1:0]      RRESP,
    output logic            RVALID,
    input  logic            RREADY,
    output logic            char_valid,
    output logic [7:0]      char_data,
    input  logic            char_ready,
    output logic            finish_valid,
    output logic [7:0]      finish_code
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int LW  = FAW + 1;
    localparam logic [AW-1:0] BASE_A = AW'(BASE);

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_RESP} rstate_e;
    typedef enum logic [2:0] {K_NONE, K_CHAR, K_FINISH, K_CYC_LO, K_CYC_HI, K_SCRATCH, K_TMR_LO, K_TMR_HI} kind_e;
    typedef struct packed {
        kind_e      kind;
        logic [2:0] tidx;
    } dec_t;

    // K_NONE marks any address that must answer SLVERR
    function automatic dec_t decode(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        logic [3:0]    t;
        dec_t          d;
        off    = addr - BASE_A;
        t      = off[7:4] - 4'd4;
        d.kind = K_NONE;
        d.tidx = t[2:0];
        if ((off >> 8) == '0) begin
            case (off[7:3])
                5'd0:    d.kind = K_CHAR;
                5'd1:    d.kind = K_FINISH;
                5'd2:    d.kind = K_CYC_LO;
                5'd3:    d.kind = K_CYC_HI;
                5'd4:    d.kind = K_SCRATCH;
                default: if (off[7:4] >= 4'd4 && off[7:4] <= 4'd11 && int'(t) < NUM_TIMERS)
                             d.kind = off[3] ? K_TMR_HI : K_TMR_LO;
            endcase
        end
        return d;
    endfunction

    wstate_e               wstate_q, wstate_d;
    rstate_e               rstate_q, rstate_d;
    logic                  aw_got_q, w_got_q;
    logic [AW-1:0]         awaddr_q;
    logic [DW-1:0]         wdata_q;
    logic [DW/8-1:0]       wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DW-1:0]         rdata_q, scratch_q;
    logic [63:0]           cycle_q;
    logic [63:0]           tcount_q [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] trun_q;
    logic [7:0]            fifo_q [FIFO_DEPTH];
    logic [FAW-1:0]        wptr_q, rptr_q;
    logic [LW-1:0]         level_q;
    logic                  fin_valid_q;
    logic [7:0]            fin_code_q;

    dec_t          wdec, rdec;
    logic          aw_hs, w_hs, ar_hs, r_hs, b_hs;
    logic          full, pop, push, stall, exec;
    logic [DW-1:0] rd_val;
    logic [63:0]   tsel;

    assign wdec         = decode(awaddr_q);
    assign rdec         = decode(ARADDR);
    assign full         = (level_q == LW'(FIFO_DEPTH));
    assign char_valid   = (level_q != '0);
    assign char_data    = fifo_q[rptr_q];
    assign pop          = char_valid & char_ready;
    // a full FIFO still accepts the push when the head leaves in the same cycle
    assign stall        = (wdec.kind == K_CHAR) & wstrb_q[0] & full & ~pop;
    assign exec         = (wstate_q == W_EXEC) & ~stall;
    assign push         = exec & (wdec.kind == K_CHAR) & wstrb_q[0];
    assign BRESP        = bresp_q;
    assign RDATA        = rdata_q;
    assign RRESP        = rresp_q;
    assign finish_valid = fin_valid_q;
    assign finish_code  = fin_code_q;

    always_comb begin
        wstate_d = wstate_q;
        rstate_d = rstate_q;
        AWREADY  = (wstate_q == W_IDLE) && !aw_got_q;
        WREADY   = (wstate_q == W_IDLE) && !w_got_q;
        BVALID   = (wstate_q == W_RESP);
        ARREADY  = (rstate_q == R_IDLE);
        RVALID   = (rstate_q == R_RESP);
        aw_hs    = AWVALID & AWREADY;
        w_hs     = WVALID & WREADY;
        b_hs     = BVALID & BREADY;
        ar_hs    = ARVALID & ARREADY;
        r_hs     = RVALID & RREADY;
        case (wstate_q)
            W_IDLE:  if ((aw_got_q | aw_hs) & (w_got_q | w_hs)) wstate_d = W_EXEC;
            W_EXEC:  if (!stall) wstate_d = W_RESP;
            W_RESP:  if (b_hs) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_RESP;
            R_RESP:  if (r_hs) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        tsel = '0;
        for (int i = 0; i < NUM_TIMERS; i++)
            if (rdec.tidx == 3'(i)) tsel = tcount_q[i];
        rd_val = '0;
        case (rdec.kind)
            K_CHAR:    rd_val = DW'(level_q);
            K_FINISH:  rd_val = DW'({fin_valid_q, fin_code_q});
            K_CYC_LO:  rd_val = DW'(cycle_q);
            K_CYC_HI:  rd_val = DW'(cycle_q[63:32]);
            K_SCRATCH: rd_val = scratch_q;
            K_TMR_LO:  rd_val = DW'(tsel);
            K_TMR_HI:  rd_val = DW'(tsel[63:32]);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bresp_q     <= '0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            scratch_q   <= '0;
            cycle_q     <= '0;
            trun_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            fin_valid_q <= 1'b0;
            fin_code_q  <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) tcount_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (aw_hs) begin
                awaddr_q <= AWADDR;
                aw_got_q <= 1'b1;
            end
            if (w_hs) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
                w_got_q <= 1'b1;
            end
            if (b_hs) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
            end
            if (exec) bresp_q <= (wdec.kind == K_NONE) ? 2'b10 : 2'b00;
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= (rdec.kind == K_NONE) ? 2'b10 : 2'b00;
            end
            if (push) begin
                fifo_q[wptr_q] <= wdata_q[7:0];
                wptr_q         <= wptr_q + FAW'(1);
            end
            if (pop) rptr_q <= rptr_q + FAW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
            if (exec && wdec.kind == K_FINISH && wstrb_q[0] && !fin_valid_q) begin
                fin_valid_q <= 1'b1;
                fin_code_q  <= wdata_q[7:0];
            end
            if (exec && wdec.kind == K_SCRATCH)
                for (int b = 0; b < DW/8; b++)
                    if (wstrb_q[b]) scratch_q[8*b +: 8] <= wdata_q[8*b +: 8];
            // command bit0 forces run, bit1 clears and otherwise keeps run as is
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (exec && wdec.kind == K_TMR_LO && wdec.tidx == 3'(i) && wstrb_q[0]) begin
                    trun_q[i]   <= wdata_q[0] | (wdata_q[1] & trun_q[i]);
                    tcount_q[i] <= wdata_q[1] ? 64'd0 : tcount_q[i] + 64'(trun_q[i]);
                end else if (trun_q[i]) begin
                    tcount_q[i] <= tcount_q[i] + 64'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tb_debug_port.sv
// tb/tb_tb_debug_port.sv - scoreboard bench for the AXI4-Lite debug port
module tb_tb_debug_port;
    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        CLK = 1'b0, RST = 1'b1;
    logic [31:0] AWADDR = '0, ARADDR = '0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic [63:0] WDATA = '0;
    logic [7:0]  WSTRB = '0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [63:0] RDATA;
    logic        char_valid, char_ready = 1'b0, finish_valid;
    logic [7:0]  char_data, finish_code;

    int n_cmp = 0, n_err = 0, cyc = 0;
    logic [7:0] exp_chars[$];
    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        string       tag;
    } rexp_t;
    rexp_t rd_q[$];

    tb_debug_port dut (
        .CLK(CLK), .RST(RST),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .finish_valid(finish_valid), .finish_code(finish_code)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        #2;
        if (!RST && char_valid && char_ready) begin
            if (exp_chars.size() == 0) check("char_unexpected", 1, 0);
            else check("char_data", char_data, exp_chars.pop_front());
        end
    end

    task automatic rd_raw(input logic [31:0] addr, output logic [63:0] data, output logic [1:0] resp, output int hs);
        int n;
        @(negedge CLK);
        ARADDR = addr;
        ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge CLK); n++; end
        @(negedge CLK);
        ARVALID = 1'b0;
        hs = cyc;
        RREADY = 1'b1;
        n = 0;
        while (!RVALID && n < 50) begin @(negedge CLK); n++; end
        check("r_latency", n, 0);
        data = RDATA;
        resp = RRESP;
        @(negedge CLK);
        RREADY = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [31:0] addr, input logic [63:0] exp_data, input logic [1:0] exp_resp);
        logic [63:0] d;
        logic [1:0]  r;
        int          hs;
        rexp_t       e;
        rd_q.push_back('{exp_data, exp_resp, tag});
        rd_raw(addr, d, r, hs);
        e = rd_q.pop_front();
        check({e.tag, "_data"}, d, e.data);
        check({e.tag, "_resp"}, 64'(r), 64'(e.resp));
    endtask

    task automatic wr_start(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb, input int aw_delay, output int hs);
        int   n;
        logic aw_hs, w_hs, aw_done, w_done;
        @(negedge CLK);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        WVALID = 1'b1;
        AWVALID = (aw_delay == 0);
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(negedge CLK);
            n++;
            if (aw_hs) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_hs) begin WVALID = 1'b0; w_done = 1'b1; end
            if (n == aw_delay) AWVALID = 1'b1;
        end
        if (!(aw_done && w_done)) check("aw_w_timeout", 0, 1);
        hs = cyc;
    endtask

    task automatic wr_finish(input int hs, input bit chk_lat, output logic [1:0] resp);
        int n;
        BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 200) begin @(negedge CLK); n++; end
        if (!BVALID) check("b_timeout", 0, 1);
        if (chk_lat) check("b_latency", cyc - hs, 1);
        resp = BRESP;
        @(negedge CLK);
        BREADY = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                      input logic [1:0] exp_resp, output int hs);
        logic [1:0] r;
        wr_start(addr, data, strb, 0, hs);
        wr_finish(hs, 1'b1, r);
        check(tag, 64'(r), 64'(exp_resp));
    endtask

    task automatic put_char(input logic [7:0] c);
        int hs;
        exp_chars.push_back(c);
        wr("char_bresp", BASE, {56'd0, c}, 8'h01, 2'b00, hs);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          h1, h2, ha, hr, n;
        logic [63:0] d1, d2;
        logic [1:0]  r1, r2;

        repeat (3) @(negedge CLK);
        check("reset_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, char_valid, finish_valid, finish_code},
              {3'b111, 16'd0});
        check("reset_rdata", RDATA, 0);
        RST = 1'b0;

        rd_raw(BASE + 32'h10, d1, r1, h1);
        repeat (2) @(negedge CLK);
        rd_raw(BASE + 32'h10, d2, r2, h2);
        check("cycle_delta", d2 - d1, h2 - h1);
        check("cycle_rresp", {r1, r2}, 0);
        rd_expect("cycle_hi", BASE + 32'h18, 0, 2'b00);
        wr("cycle_wr_okay", BASE + 32'h10, 64'd0, 8'hFF, 2'b00, ha);

        put_char(8'h48);
        put_char(8'h69);
        rd_expect("char_level2", BASE, 2, 2'b00);
        char_ready = 1'b1;
        @(negedge CLK);
        check("char_valid_mid", char_valid, 1);
        @(negedge CLK);
        check("char_drained", {char_valid, exp_chars.size() == 0}, 2'b01);
        char_ready = 1'b0;

        for (int i = 0; i < 16; i++) put_char(8'h61 + 8'(i));
        rd_expect("char_level_full", BASE, 16, 2'b00);
        exp_chars.push_back(8'h5A);
        wr_start(BASE, 64'h5A, 8'h01, 0, ha);
        repeat (10) @(negedge CLK);
        check("b_stall", BVALID, 0);
        char_ready = 1'b1;
        @(negedge CLK);
        char_ready = 1'b0;
        wr_finish(ha, 1'b0, r1);
        check("stall_bresp", 64'(r1), 0);
        rd_expect("char_level_refill", BASE, 16, 2'b00);
        char_ready = 1'b1;
        n = 0;
        while (exp_chars.size() != 0 && n < 100) begin @(negedge CLK); n++; end
        char_ready = 1'b0;
        check("fifo_drain_left", exp_chars.size(), 0);
        check("fifo_drain_valid", char_valid, 0);

        wr("tmr_start", BASE + 32'h40, 64'd1, 8'h01, 2'b00, h1);
        repeat (100) @(negedge CLK);
        wr("tmr_stop", BASE + 32'h40, 64'd0, 8'h01, 2'b00, h2);
        rd_expect("tmr0_count", BASE + 32'h40, h2 - h1, 2'b00);
        rd_expect("tmr0_hi", BASE + 32'h48, 0, 2'b00);
        wr("tmr_clear", BASE + 32'h40, 64'd2, 8'h01, 2'b00, ha);
        rd_expect("tmr0_cleared", BASE + 32'h40, 0, 2'b00);
        wr("tmr1_clr_start", BASE + 32'h50, 64'd3, 8'h01, 2'b00, ha);
        rd_raw(BASE + 32'h50, d1, r1, hr);
        check("tmr1_count", d1, hr - ha - 2);
        rd_expect("tmr3_idle", BASE + 32'h70, 0, 2'b00);
        rd_expect("tmr4_unmapped", BASE + 32'h80, 0, 2'b10);
        wr("tmr4_wr_slverr", BASE + 32'h80, 64'd1, 8'h01, 2'b10, ha);

        wr("finish_first", BASE + 32'h08, 64'h2A, 8'h01, 2'b00, ha);
        wr("finish_second", BASE + 32'h08, 64'h07, 8'h01, 2'b00, ha);
        check("finish_ports", {finish_valid, finish_code}, 9'h12A);
        rd_expect("finish_rd", BASE + 32'h08, 64'h12A, 2'b00);

        rd_expect("unmapped_fc", BASE + 32'hFC, 0, 2'b10);
        rd_expect("unmapped_28", BASE + 32'h28, 0, 2'b10);
        rd_expect("below_base", BASE - 32'h8, 0, 2'b10);
        wr("oob_wr", BASE + 32'h100, 64'h58, 8'h01, 2'b10, ha);
        rd_expect("oob_no_push", BASE, 0, 2'b00);
        rd_expect("scratch_rst", BASE + 32'h20, 0, 2'b00);
        wr("scratch_wr", BASE + 32'h20, '1, 8'h0F, 2'b00, ha);
        rd_expect("scratch_merge", BASE + 32'h20, 64'h0000_0000_FFFF_FFFF, 2'b00);
        wr("scratch_wr2", BASE + 32'h20, 64'h1122_3344_5566_7788, 8'hA0, 2'b00, ha);
        rd_expect("scratch_merge2", BASE + 32'h20, 64'h1100_3300_FFFF_FFFF, 2'b00);
        wr_start(BASE + 32'h20, 64'hAB, 8'h01, 3, ha);
        wr_finish(ha, 1'b1, r1);
        check("w_first_bresp", 64'(r1), 0);
        rd_expect("w_first_data", BASE + 32'h20, 64'h1100_3300_FFFF_FFAB, 2'b00);

        @(negedge CLK);
        ARADDR = BASE + 32'h20; ARVALID = 1'b1;
        AWADDR = BASE + 32'h08; AWVALID = 1'b1;
        @(negedge CLK);
        ARVALID = 1'b0; AWVALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, finish_valid, finish_code},
              {3'b111, 2'b00, 1'b0, 8'h00});
        rd_expect("scratch_after_rst", BASE + 32'h20, 0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
